parking_controller_fsm: RTL and testbench



---
 rtl/parking_controller_fsm.sv | 115 +++++++++++
 tb/tb_parking_controller_fsm.sv | 138 +++++++++++++
 2 files changed

// File: rtl/parking_controller_fsm.sv
`default_nettype none
// ============================================================================
// Module   : parking_controller_fsm
// Purpose  : Single-lane parking gate controller; PIN entry, gate command,
//            wrong-PIN and tailgating alarms (Moore FSM).
// Revision : 1.0  initial release
// ============================================================================
module parking_controller_fsm #(
   parameter logic [7:0] CORRECT_PIN  = 8'h47,
   parameter int         MAX_ATTEMPTS = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] pin,
   input  logic       senr_e,
   input  logic       senr_x,
   output logic       gate_o,
   output logic       gate_cls,
   output logic       alm_pin,
   output logic       alm_blkg
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_PIN  = 3'd1,
      GATE_OPEN = 3'd2,
      ALM_PIN   = 3'd3,
      ALM_BLKG  = 3'd4
   } state_t;

   localparam logic [1:0] c_max = 2'(MAX_ATTEMPTS);

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_cnt;
   logic [1:0] w_cnt_next;
   logic [1:0] w_cnt_sat;
   logic       r_armed;
   logic       w_attempt;
   logic       w_ok;
   logic       w_bad;

   assign w_attempt = (pin != 8'h00) && r_armed;
   assign w_ok      = w_attempt && (pin == CORRECT_PIN);
   assign w_bad     = w_attempt && (pin != CORRECT_PIN);
   assign w_cnt_sat = (r_cnt == c_max) ? r_cnt : r_cnt + 2'd1;

   // A nonzero pin either consumes the arm or finds it already cleared,
   // so the flag simply tracks whether the keypad was idle last cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= 2'd0;
         r_armed <= 1'b1;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         r_armed <= (pin == 8'h00);
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      gate_o     = 1'b0;
      gate_cls   = 1'b1;
      alm_pin    = 1'b0;
      alm_blkg   = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_next = 2'd0;
            if (senr_e) w_next = WAIT_PIN;
         end
         WAIT_PIN: begin
            if (w_ok) begin
               w_next     = GATE_OPEN;
               w_cnt_next = 2'd0;
            end else if (w_bad) begin
               w_cnt_next = w_cnt_sat;
               if (w_cnt_sat == c_max) w_next = ALM_PIN;
            end else if (!senr_e) begin
               w_next     = IDLE;
               w_cnt_next = 2'd0;
            end
         end
         GATE_OPEN: begin
            gate_o   = 1'b1;
            gate_cls = 1'b0;
            // Two vehicles across the gate at once wins over a clean exit.
            if (senr_e && senr_x)      w_next = ALM_BLKG;
            else if (senr_x && !senr_e) w_next = IDLE;
         end
         ALM_PIN: begin
            alm_pin = 1'b1;
            if (w_ok) begin
               w_next     = GATE_OPEN;
               w_cnt_next = 2'd0;
            end
         end
         ALM_BLKG: begin
            alm_blkg = 1'b1;
            if (w_ok) begin
               w_next     = IDLE;
               w_cnt_next = 2'd0;
            end
         end
         default: begin
            w_next     = IDLE;
            w_cnt_next = 2'd0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_parking_controller_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_controller_fsm
// Purpose  : Scoreboard bench for parking_controller_fsm.
// Revision : 1.0  initial release
// ============================================================================
module tb_parking_controller_fsm;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] pin   = 8'h00;
   logic       senr_e = 1'b0;
   logic       senr_x = 1'b0;
   logic       gate_o, gate_cls, alm_pin, alm_blkg;

   // Output vector order: {gate_o, gate_cls, alm_pin, alm_blkg}
   localparam logic [3:0] c_closed = 4'b0100;
   localparam logic [3:0] c_open   = 4'b1000;
   localparam logic [3:0] c_apin   = 4'b0110;
   localparam logic [3:0] c_ablk   = 4'b0101;

   int         n_checks = 0;
   int         n_errors = 0;
   string      q_tag[$];
   logic [3:0] q_exp[$];

   parking_controller_fsm dut (
      .clock    (clock),
      .reset    (reset),
      .pin      (pin),
      .senr_e   (senr_e),
      .senr_x   (senr_x),
      .gate_o   (gate_o),
      .gate_cls (gate_cls),
      .alm_pin  (alm_pin),
      .alm_blkg (alm_blkg)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%b expected=%b", tag, got, exp);
      end
   endtask

   // One cycle of stimulus plus the outputs expected after the next edge.
   task automatic step(input string tag, input logic r, input logic [7:0] p,
                       input logic e, input logic x, input logic [3:0] exp);
      @(negedge clock);
      reset  = r;
      pin    = p;
      senr_e = e;
      senr_x = x;
      q_tag.push_back(tag);
      q_exp.push_back(exp);
   endtask

   always @(posedge clock) begin
      #1;
      if (q_exp.size() > 0) begin
         check_eq(q_tag.pop_front(), {gate_o, gate_cls, alm_pin, alm_blkg}, q_exp.pop_front());
      end
   end

   initial begin
      // Reset with arbitrary inputs
      step("rst0", 1, 8'h55, 1, 1, c_closed);
      step("rst1", 1, 8'h47, 1, 1, c_closed);

      // Normal entry and exit
      step("ne_wait",  0, 8'h00, 1, 0, c_closed);
      step("ne_pin",   0, 8'h47, 1, 0, c_open);
      step("ne_hold",  0, 8'h00, 0, 0, c_open);
      step("ne_exit",  0, 8'h00, 0, 1, c_closed);
      step("ne_idle",  0, 8'h00, 0, 0, c_closed);

      // Two wrong then correct
      step("wc_wait",  0, 8'h00, 1, 0, c_closed);
      step("wc_w1",    0, 8'h11, 1, 0, c_closed);
      step("wc_z1",    0, 8'h00, 1, 0, c_closed);
      step("wc_w2",    0, 8'h12, 1, 0, c_closed);
      step("wc_z2",    0, 8'h00, 1, 0, c_closed);
      step("wc_ok",    0, 8'h47, 1, 0, c_open);
      step("wc_exit",  0, 8'h00, 0, 1, c_closed);

      // Three wrong -> alarm; alarm ignores wrong pins and sensors
      step("tw_wait",  0, 8'h00, 1, 0, c_closed);
      step("tw_w1",    0, 8'h11, 1, 0, c_closed);
      step("tw_z1",    0, 8'h00, 1, 0, c_closed);
      step("tw_w2",    0, 8'h22, 1, 0, c_closed);
      step("tw_z2",    0, 8'h00, 1, 0, c_closed);
      step("tw_w3",    0, 8'h33, 1, 0, c_apin);
      step("tw_z3",    0, 8'h00, 1, 0, c_apin);
      step("tw_w4",    0, 8'h44, 1, 0, c_apin);
      step("tw_z4",    0, 8'h00, 0, 1, c_apin);
      step("tw_ok",    0, 8'h47, 0, 0, c_open);
      step("tw_exit",  0, 8'h00, 0, 1, c_closed);

      // Held pin counts once; IDLE clears the counter
      step("hp_wait",  0, 8'h00, 1, 0, c_closed);
      for (int i = 0; i < 5; i++) step("hp_hold", 0, 8'h11, 1, 0, c_closed);
      step("hp_z1",    0, 8'h00, 1, 0, c_closed);
      step("hp_w2",    0, 8'h22, 1, 0, c_closed);
      step("hp_leave", 0, 8'h00, 0, 0, c_closed);
      step("hp_wait2", 0, 8'h00, 1, 0, c_closed);
      step("hp_w3",    0, 8'h33, 1, 0, c_closed);
      step("hp_z3",    0, 8'h00, 1, 0, c_closed);
      step("hp_ok",    0, 8'h47, 1, 0, c_open);

      // Tailgating alarm
      step("bk_both",  0, 8'h00, 1, 1, c_ablk);
      step("bk_wrong", 0, 8'h99, 1, 1, c_ablk);
      step("bk_z",     0, 8'h00, 1, 1, c_ablk);
      step("bk_ok",    0, 8'h47, 1, 0, c_closed);
      step("bk_rewait",0, 8'h00, 1, 0, c_closed);
      step("bk_nowait",0, 8'h00, 1, 1, c_closed);
      step("bk_ok2",   0, 8'h47, 1, 0, c_open);
      step("bk_both2", 0, 8'h00, 1, 1, c_ablk);
      step("bk_rst",   1, 8'h00, 1, 1, c_closed);
      step("bk_idle",  0, 8'h00, 0, 0, c_closed);

      // Reset while the gate is open
      step("ro_wait",  0, 8'h00, 1, 0, c_closed);
      step("ro_ok",    0, 8'h47, 1, 0, c_open);
      step("ro_rst",   1, 8'h00, 1, 0, c_closed);
      step("ro_idle",  0, 8'h00, 0, 0, c_closed);

      repeat (3) @(negedge clock);
      check_eq("drain", 4'(q_exp.size()), 4'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
